// File: rtl/pwm_capture.sv
// ============================================================================
// pwm_capture : recovers 8-bit duty code and period from a PWM input
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_capture #(
   parameter int STEP    = 2,
   parameter int TIMEOUT = 1024,
   parameter int CW      = 16
) (
   input  logic          SysClk,
   input  logic          Reset,
   input  logic          PwmIn,
   output logic [7:0]    Duty,
   output logic [CW-1:0] Period,
   output logic          DutyValid,
   output logic          Locked
);

   localparam logic [1:0] c_WAIT_RISE = 2'd0;
   localparam logic [1:0] c_MEAS_HIGH = 2'd1;
   localparam logic [1:0] c_MEAS_LOW  = 2'd2;
   localparam logic [1:0] c_STUCK     = 2'd3;

   localparam logic [CW-1:0] c_ONE        = CW'(1);
   localparam logic [CW-1:0] c_IDLE_LIMIT = CW'(TIMEOUT - 1);
   localparam int            c_PW         = CW + 8;

   logic          r_s1, r_s2, r_s3;
   logic [1:0]    r_state;
   logic [CW-1:0] r_per_cnt, r_high_cnt, r_idle_cnt;
   logic [7:0]    r_duty;
   logic [CW-1:0] r_period;
   logic          r_valid, r_locked;

   logic          w_rise, w_fall, w_timeout;
   logic [CW-1:0] w_per_inc, w_high_inc, w_idle_inc;
   logic [c_PW-1:0] w_prod;
   logic [7:0]    w_duty_sat;

   assign w_rise = r_s2 & ~r_s3;
   assign w_fall = ~r_s2 & r_s3;

   assign w_per_inc  = (r_per_cnt  == '1) ? r_per_cnt  : r_per_cnt  + c_ONE;
   assign w_high_inc = (r_high_cnt == '1) ? r_high_cnt : r_high_cnt + c_ONE;
   assign w_idle_inc = (r_idle_cnt == '1) ? r_idle_cnt : r_idle_cnt + c_ONE;

   // An edge in the same cycle always wins over the timeout.
   assign w_timeout = (r_idle_cnt == c_IDLE_LIMIT) && !w_rise && !w_fall
                      && (r_state != c_STUCK);

   assign w_prod     = c_PW'(r_high_cnt) * c_PW'(STEP);
   assign w_duty_sat = (w_prod > c_PW'(255)) ? 8'hFF : w_prod[7:0];

   always_ff @(posedge SysClk) begin
      if (Reset) begin
         r_s1       <= 1'b0;
         r_s2       <= 1'b0;
         r_s3       <= 1'b0;
         r_state    <= c_WAIT_RISE;
         r_per_cnt  <= '0;
         r_high_cnt <= '0;
         r_idle_cnt <= '0;
         r_duty     <= 8'd0;
         r_period   <= '0;
         r_valid    <= 1'b0;
         r_locked   <= 1'b0;
      end else begin
         r_s1       <= PwmIn;
         r_s2       <= r_s1;
         r_s3       <= r_s2;
         r_valid    <= 1'b0;
         r_idle_cnt <= (w_rise | w_fall) ? '0 : w_idle_inc;

         case (r_state)
            c_WAIT_RISE: begin
               if (w_rise) begin
                  r_state    <= c_MEAS_HIGH;
                  r_per_cnt  <= c_ONE;
                  r_high_cnt <= c_ONE;
               end
            end
            c_MEAS_HIGH: begin
               r_per_cnt <= w_per_inc;
               if (w_fall) begin
                  r_state <= c_MEAS_LOW;
               end else begin
                  r_high_cnt <= w_high_inc;
               end
            end
            c_MEAS_LOW: begin
               if (w_rise) begin
                  r_period   <= r_per_cnt;
                  r_duty     <= w_duty_sat;
                  r_valid    <= 1'b1;
                  r_locked   <= 1'b1;
                  r_per_cnt  <= c_ONE;
                  r_high_cnt <= c_ONE;
                  r_state    <= c_MEAS_HIGH;
               end else begin
                  r_per_cnt <= w_per_inc;
               end
            end
            c_STUCK: begin
               if (w_rise) begin
                  r_state    <= c_MEAS_HIGH;
                  r_per_cnt  <= c_ONE;
                  r_high_cnt <= c_ONE;
               end else if (w_fall) begin
                  r_state <= c_WAIT_RISE;
               end
            end
            default: r_state <= c_WAIT_RISE;
         endcase

         // Stuck entry overrides the state update above; only reachable without an edge.
         if (w_timeout) begin
            r_state  <= c_STUCK;
            r_duty   <= r_s2 ? 8'hFF : 8'h00;
            r_period <= '0;
            r_locked <= 1'b0;
            r_valid  <= 1'b1;
         end
      end
   end

   assign Duty      = r_duty;
   assign Period    = r_period;
   assign DutyValid = r_valid;
   assign Locked    = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: timestamp-based reference model checked every cycle,
// plus directed scenarios with literal expectations and a randomized phase.
`default_nettype none

module tb_pwm_capture;

   localparam int TIMEOUT = 1024;

   logic        SysClk;
   logic        Reset;
   logic        PwmIn;
   logic [7:0]  Duty;
   logic [15:0] Period;
   logic        DutyValid;
   logic        Locked;

   pwm_capture #(.STEP(2), .TIMEOUT(TIMEOUT), .CW(16)) dut (
      .SysClk    (SysClk),
      .Reset     (Reset),
      .PwmIn     (PwmIn),
      .Duty      (Duty),
      .Period    (Period),
      .DutyValid (DutyValid),
      .Locked    (Locked)
   );

   initial begin
      SysClk = 1'b0;
      forever #5 SysClk = ~SysClk;
   end

   int n_vec = 0;
   int n_mis = 0;

   // Reference model: synchronizer delay line plus event timestamps.
   bit   m_d1, m_d2, m_d3;
   int   m_cyc, m_last_edge, m_rise_t, m_fall_t;
   bit   m_armed, m_fell, m_stuck;
   logic [7:0]  exp_duty;
   logic [15:0] exp_period;
   logic        exp_locked, exp_valid;

   int   dut_pulses = 0;
   int   last_duty, last_period, last_locked;

   task automatic model_step(input bit rst, input bit pwm);
      bit rise, fall;
      int hd;
      if (rst) begin
         m_d1 = 0; m_d2 = 0; m_d3 = 0;
         m_cyc = 0; m_last_edge = 0;
         m_armed = 0; m_fell = 0; m_stuck = 0;
         exp_duty = 8'd0; exp_period = 16'd0; exp_locked = 1'b0; exp_valid = 1'b0;
         return;
      end
      rise = m_d2 && !m_d3;
      fall = !m_d2 && m_d3;
      exp_valid = 1'b0;
      if (rise) begin
         if (m_armed && m_fell) begin
            hd = 2 * (m_fall_t - m_rise_t);
            exp_duty   = (hd > 255) ? 8'd255 : 8'(hd);
            exp_period = 16'(m_cyc - m_rise_t);
            exp_locked = 1'b1;
            exp_valid  = 1'b1;
         end
         m_armed = 1; m_fell = 0; m_stuck = 0;
         m_rise_t = m_cyc;
         m_last_edge = m_cyc + 1;
      end else if (fall) begin
         if (m_armed) begin
            m_fell = 1;
            m_fall_t = m_cyc;
         end
         m_stuck = 0;
         m_last_edge = m_cyc + 1;
      end else if (!m_stuck && (m_cyc - m_last_edge) == TIMEOUT - 1) begin
         m_stuck = 1; m_armed = 0; m_fell = 0;
         exp_duty   = m_d2 ? 8'd255 : 8'd0;
         exp_period = 16'd0;
         exp_locked = 1'b0;
         exp_valid  = 1'b1;
      end
      m_d3 = m_d2; m_d2 = m_d1; m_d1 = pwm;
      m_cyc++;
   endtask

   initial begin : compare
      bit s_rst, s_pwm;
      forever begin
         @(posedge SysClk);
         s_rst = Reset;
         s_pwm = PwmIn;
         #1;
         model_step(s_rst, s_pwm);
         n_vec++;
         if (Duty !== exp_duty || Period !== exp_period ||
             Locked !== exp_locked || DutyValid !== exp_valid) begin
            n_mis++;
            if (n_mis <= 20)
               $display("FAIL cycle_check t=%0t duty=%0d exp %0d period=%0d exp %0d locked=%0b exp %0b valid=%0b exp %0b",
                        $time, Duty, exp_duty, Period, exp_period, Locked, exp_locked, DutyValid, exp_valid);
         end
         if (DutyValid === 1'b1) begin
            dut_pulses++;
            last_duty   = int'(Duty);
            last_period = int'(Period);
            last_locked = int'(Locked);
         end
      end
   end

   task automatic pin(input string name, input int actual, input int expected);
      n_vec++;
      if (actual != expected) begin
         n_mis++;
         $display("FAIL %s got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic wave(input int h, input int l, input int reps);
      for (int r = 0; r < reps; r++) begin
         PwmIn = 1'b1;
         repeat (h) @(negedge SysClk);
         PwmIn = 1'b0;
         repeat (l) @(negedge SysClk);
      end
   endtask

   task automatic hold(input bit lvl, input int n);
      PwmIn = lvl;
      repeat (n) @(negedge SysClk);
   endtask

   task automatic pulse_reset();
      Reset = 1'b1;
      @(negedge SysClk);
      Reset = 1'b0;
   endtask

   task automatic pin_last(input string name, input int d, input int p, input int lk);
      pin({name, "_duty"},   last_duty,   d);
      pin({name, "_period"}, last_period, p);
      pin({name, "_locked"}, last_locked, lk);
   endtask

   initial begin : stim
      int p0;
      Reset = 1'b1;
      PwmIn = 1'b0;
      repeat (3) @(negedge SysClk);
      pin("rst_duty",   int'(Duty),      0);
      pin("rst_period", int'(Period),    0);
      pin("rst_locked", int'(Locked),    0);
      pin("rst_valid",  int'(DutyValid), 0);
      Reset = 1'b0;

      // 50 high / 78 low: first update at the second rise.
      p0 = dut_pulses;
      wave(50, 78, 5);
      hold(1'b0, 4);
      pin("lock_pulses", dut_pulses - p0, 4);
      pin_last("lock", 100, 128, 1);
      pin("model_lock_duty", int'(exp_duty), 100);
      pin("model_lock_period", int'(exp_period), 128);

      // Stuck high then resume.
      p0 = dut_pulses;
      hold(1'b1, 1100);
      pin("stuckhi_pulses", dut_pulses - p0, 2);
      pin_last("stuckhi", 255, 0, 0);
      pin("model_stuckhi_duty", int'(exp_duty), 255);
      p0 = dut_pulses;
      hold(1'b0, 78);
      wave(50, 78, 3);
      hold(1'b0, 4);
      pin("resume_pulses", dut_pulses - p0, 2);
      pin_last("resume", 100, 128, 1);

      // Stuck low straight after reset.
      pulse_reset();
      p0 = dut_pulses;
      hold(1'b0, 1100);
      pin("stucklo_pulses", dut_pulses - p0, 1);
      pin_last("stucklo", 0, 0, 0);

      // Saturation and extreme duty cycles.
      p0 = dut_pulses;
      wave(200, 56, 3);
      pin("sat_pulses", dut_pulses - p0, 2);
      pin_last("sat", 255, 256, 1);
      wave(1, 127, 3);
      pin_last("min", 2, 128, 1);
      wave(127, 1, 3);
      hold(1'b0, 4);
      pin_last("max", 254, 128, 1);

      // Reset in the middle of a high phase.
      wave(50, 78, 3);
      hold(1'b1, 20);
      pulse_reset();
      pin("midrst_duty",   int'(Duty),   0);
      pin("midrst_period", int'(Period), 0);
      pin("midrst_locked", int'(Locked), 0);
      p0 = dut_pulses;
      hold(1'b1, 30);
      hold(1'b0, 78);
      wave(50, 78, 3);
      hold(1'b0, 4);
      pin("midrst_pulses", dut_pulses - p0, 3);
      pin_last("midrst", 100, 128, 1);

      // Randomized segments; the per-cycle model check covers them.
      for (int i = 0; i < 40; i++) begin
         int kind;
         kind = int'($urandom_range(0, 9));
         if (kind == 0)
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1030, 1200)));
         else if (kind == 1)
            pulse_reset();
         else
            wave(int'($urandom_range(1, 200)), int'($urandom_range(1, 200)),
                 int'($urandom_range(1, 3)));
      end
      hold(1'b0, 10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Measures an incoming PWM waveform and recovers its 8-bit duty code and period in SysClk cycles. It is the receive-side counterpart of the team's PWM generator, which uses an 8-bit Duty, an internal counter stepping by 2 per clock, and a period threshold of 255. The block is used for loopback checks of RGB PWM drivers and for reading external PWM sources. It reports a duty update once per completed period, and it also reports a stuck-level (0% or 100%) condition after a timeout.

Parameters:
STEP, 2, duty units per high-time clock; the Duty output is HighCnt*STEP, saturated to 255 (this matches the generator's step of 2).
TIMEOUT, 1024, number of clocks with no edge on the input before a stuck level is declared.
CW, 16, width of the period, high-time and idle counters.

Ports:
SysClk  in  1  system clock; all logic acts on its rising edge.
Reset  in  1  synchronous, active-high reset.
PwmIn  in  1  asynchronous PWM input.
Duty  out  8  last recovered duty code.
Period  out  CW  last measured period in SysClk cycles; 0 when the input is stuck.
DutyValid  out  1  one-cycle pulse when Duty and Period update.
Locked  out  1  high while periodic edges are being measured.

Behaviour:
- Synchronizer and edge detection:
  - Two flops s1 then s2, plus a delay flop s3; all reset to 0.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - An input edge is detected 3 SysClk edges after it occurs.
- Reset values: Duty=0, Period=0, DutyValid=0, Locked=0, state=WAIT_RISE, all counters 0.
- Counters:
  - PerCnt, HighCnt and IdleCnt are CW bits wide and saturate at all-ones; they never wrap.
  - IdleCnt clears on any rise or fall and otherwise increments every cycle.
- States:
  - WAIT_RISE:
    - On rise -> MEAS_HIGH with PerCnt=1 and HighCnt=1.
    - No output update here: the first rise after reset or after STUCK produces no DutyValid.
  - MEAS_HIGH:
    - PerCnt++ and HighCnt++ each cycle.
    - On fall -> MEAS_LOW; HighCnt is not incremented in the fall cycle.
  - MEAS_LOW:
    - PerCnt++ each cycle.
    - On rise, in the same cycle:
      - Period<=PerCnt.
      - Duty<=min(HighCnt*STEP, 255), with the product computed at CW+8 bits.
      - DutyValid<=1 and Locked<=1.
      - PerCnt<=1, HighCnt<=1, -> MEAS_HIGH.
  - STUCK:
    - On rise -> MEAS_HIGH with counts restarted; no output update.
    - On fall -> WAIT_RISE.
    - Duty, Period and Locked hold their values.
- Timeout:
  - In WAIT_RISE, MEAS_HIGH or MEAS_LOW, when IdleCnt reaches TIMEOUT-1 with no edge in that cycle, the block -> STUCK.
  - In that same cycle: Duty<=(s2 ? 255 : 0), Period<=0, Locked<=0, DutyValid<=1.
  - DutyValid pulses only once per stuck episode.
- Timing rules:
  - DutyValid is registered, high for exactly one cycle, and is asserted in the cycle after the detecting edge.
  - Duty, Period and Locked change only in that same cycle.
  - If an edge and the timeout coincide, the edge takes priority.
- Period/duty relations:
  - A period of P clocks with H high clocks gives Period=P and Duty=min(H*STEP, 255).
  - Duty is not normalised to the period; the STEP scaling relies on the generator's fixed period.
- Reset in mid-measurement: all state returns to its reset value on the next clock. Partial counts are discarded and no DutyValid is produced.

Test Plan:
- Reset, then drive PwmIn high for 50 clocks and low for 78 clocks, repeated -> first DutyValid appears at the second rise; Duty=100, Period=128, Locked=1; a DutyValid pulse follows every 128 clocks.
- Hold PwmIn low for 1100 clocks after reset -> single DutyValid at IdleCnt=TIMEOUT-1 with Duty=0, Period=0, Locked=0; no further pulses.
- Lock at 50/128, then hold PwmIn high -> one DutyValid with Duty=255, Period=0, Locked=0; resuming the 50/128 waveform gives Duty=100 again from the second rise after the fall.
- High 200, low 56 -> Duty=255 (400 saturated), Period=256.
- Assert Reset for 1 clock midway through a high phase -> all outputs are 0; the next DutyValid appears only after two further rises and carries correct values.
- High 1 clock, low 127 -> Duty=2, Period=128; high 127, low 1 -> Duty=254, Period=128.
